// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, the hex glyph table
// and the capture FSM state encoding.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Indexed by digit value; entry 15 is listed first in the concatenation.
  localparam logic [15:0][SEG_W-1:0] DIGIT_SEGS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SETTLING = 2'd1,
    ST_LOCKED   = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup from a normalized segment pattern to a hex digit;
// ok_o is low for any pattern that is not one of the sixteen glyphs.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] digit_o,
  output logic       ok_o
);

  // NOTE: every output gets a default before the search loop so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    digit_o = 4'h0;
    ok_o    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == DIGIT_SEGS[i]) begin
        digit_o = 4'(i);
        ok_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures the digit shown on an asynchronous seven-segment bus: synchronizes,
// debounces over STABLE_CYCLES, decodes, and flags out-of-sequence digits.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] value,
  output logic       valid,
  output logic       invalid_pattern,
  output logic       update,
  output logic       step_err,
  output logic [7:0] err_count
);

  localparam seg_t        INV_MASK   = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);

  seg_t        sync1_q, sync2_q, p_prev_q;
  seg_t        acc_q, acc_d;
  logic        have_acc_q, have_acc_d;
  logic [15:0] cnt_q, cnt_d;
  cap_state_e  state_q, state_d;
  logic [3:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic        invalid_q, invalid_d;
  logic        update_q, update_d;
  logic        step_err_q, step_err_d;
  logic [7:0]  err_count_q, err_count_d;

  seg_t       p;
  logic [3:0] dec_digit;
  logic       dec_ok;
  logic [3:0] next_value;
  logic       accept;

  assign p          = sync2_q ^ INV_MASK;
  assign next_value = value_q + 4'd1;

  seg7_to_hex u_to_hex (
    .pattern_i (p),
    .digit_o   (dec_digit),
    .ok_o      (dec_ok)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    have_acc_d  = have_acc_q;
    acc_d       = acc_q;
    value_d     = value_q;
    valid_d     = valid_q;
    invalid_d   = invalid_q;
    err_count_d = err_count_q;
    update_d    = 1'b0;
    step_err_d  = 1'b0;
    accept      = 1'b0;

    if (p != p_prev_q) begin
      state_d = ST_SETTLING;
      cnt_d   = '0;
    end else if (state_q == ST_SETTLING) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_d == STABLE_MAX) begin
        state_d = ST_LOCKED;
        accept  = 1'b1;
      end
    end

    // Re-accepting the pattern already on display is a glitch that settled back.
    if (accept && !(have_acc_q && p == acc_q)) begin
      have_acc_d = 1'b1;
      acc_d      = p;
      update_d   = 1'b1;
      if (dec_ok) begin
        step_err_d = valid_q && (dec_digit != next_value);
        value_d    = dec_digit;
        valid_d    = 1'b1;
        invalid_d  = 1'b0;
      end else begin
        valid_d   = 1'b0;
        invalid_d = 1'b1;
      end
    end

    if (step_err_d && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order. The synchronizer
  // flops are reset too, to the raw level that normalizes to a blank display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= INV_MASK;
      sync2_q     <= INV_MASK;
      p_prev_q    <= SEG_BLANK;
      acc_q       <= SEG_BLANK;
      have_acc_q  <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_UNLOCKED;
      value_q     <= 4'h0;
      valid_q     <= 1'b0;
      invalid_q   <= 1'b0;
      update_q    <= 1'b0;
      step_err_q  <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      sync1_q     <= seg_in;
      sync2_q     <= sync1_q;
      p_prev_q    <= p;
      acc_q       <= acc_d;
      have_acc_q  <= have_acc_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      invalid_q   <= invalid_d;
      update_q    <= update_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign value           = value_q;
  assign valid           = valid_q;
  assign invalid_pattern = invalid_q;
  assign update          = update_q;
  assign step_err        = step_err_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus random traffic,
// each compared against a cycle-level behavioural model of the capture rules.
module tb_seg7_capture;

  localparam int         S    = 16;
  localparam logic [6:0] MASK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] value;
  logic       valid, invalid_pattern, update, step_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .seg_in          (seg_in),
    .value           (value),
    .valid           (valid),
    .invalid_pattern (invalid_pattern),
    .update          (update),
    .step_err        (step_err),
    .err_count       (err_count)
  );

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int failures = 0;

  // Reference model state: raw input delay line, stability run, last shown pattern.
  logic [6:0] m_s1 = MASK, m_s2 = MASK, m_pprev = 7'h00, m_acc = 7'h00;
  int         m_run = 0, m_cnt = 0, m_val = 0;
  bit         m_settling = 0, m_have = 0, m_v = 0, m_inv = 0, m_upd = 0, m_serr = 0;

  int  cyc_mism = 0, n_upd = 0, n_serr = 0, n_orphan = 0;
  time first_mism_t = 0;

  function automatic void model_accept(input logic [6:0] p);
    int d = -1;
    for (int i = 0; i < 16; i++) if (tbl[i] == p) d = i;
    m_have = 1; m_acc = p; m_upd = 1;
    if (d >= 0) begin
      m_serr = m_v && (d != (m_val + 1) % 16);
      m_val = d; m_v = 1; m_inv = 0;
      if (m_serr && m_cnt < 255) m_cnt++;
    end else begin
      m_v = 0; m_inv = 1;
    end
  endfunction

  function automatic void model_edge();
    logic [6:0] p;
    m_upd = 0; m_serr = 0;
    if (!rst_n) begin
      m_s1 = MASK; m_s2 = MASK; m_pprev = 7'h00; m_run = 0; m_settling = 0;
      m_have = 0; m_acc = 7'h00; m_val = 0; m_v = 0; m_inv = 0; m_cnt = 0;
      return;
    end
    p = m_s2 ^ MASK;
    if (p != m_pprev) begin
      m_run = 0; m_settling = 1;
    end else if (m_settling) begin
      m_run++;
      if (m_run == S) begin
        m_settling = 0;
        if (!(m_have && p == m_acc)) model_accept(p);
      end
    end
    m_pprev = p; m_s2 = m_s1; m_s1 = seg_in;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (update !== m_upd || step_err !== m_serr || value !== 4'(m_val) || valid !== m_v ||
        invalid_pattern !== m_inv || err_count !== 8'(m_cnt)) begin
      if (cyc_mism == 0) first_mism_t = $time;
      cyc_mism++;
    end
    if (update === 1'b1) n_upd++;
    if (step_err === 1'b1) n_serr++;
    if (step_err === 1'b1 && update !== 1'b1) n_orphan++;
  endtask

  task automatic drive(input logic [6:0] raw, input int hold);
    seg_in = raw;
    repeat (hold) tick();
  endtask

  task automatic drive_digit(input int d, input int hold);
    drive(~tbl[d], hold);
  endtask

  // Edges from the first edge that sees raw until update rises; -1 if it never does.
  task automatic measure(input logic [6:0] raw, output int lat);
    seg_in = raw;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (update === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string name);
    checks++;
    if (cyc_mism !== 0) begin
      failures++;
      $display("FAIL %s: %0d cycles differ from model, first at t=%0t, expected 0", name, cyc_mism, first_mism_t);
    end
    checks++;
    if (n_orphan !== 0) begin
      failures++;
      $display("FAIL %s: step_err without update %0d times, expected 0", name, n_orphan);
    end
  endtask

  task automatic test_reset();
    seg_in = ~tbl[8];
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({value, valid, invalid_pattern, update, step_err, err_count} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs: got value=%0h valid=%0b inv=%0b upd=%0b serr=%0b cnt=%0h, expected all 0",
               value, valid, invalid_pattern, update, step_err, err_count);
    end
    seg_in = MASK;
    rst_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (update !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_blank_idle: got upd=%0b valid=%0b, expected 0 0", update, valid);
    end
    check_model("reset");
  endtask

  task automatic test_first_two();
    int lat, u0, s0;
    u0 = n_upd; s0 = n_serr;
    measure(~tbl[0], lat);
    checks++;
    if (lat !== S + 2) begin failures++; $display("FAIL latency_0: got %0d expected %0d", lat, S + 2); end
    repeat (5) tick();
    checks++;
    if (value !== 4'h0 || valid !== 1'b1) begin
      failures++; $display("FAIL first_digit: got value=%0h valid=%0b expected 0 1", value, valid);
    end
    measure(~tbl[1], lat);
    checks++;
    if (lat !== S + 2) begin failures++; $display("FAIL latency_1: got %0d expected %0d", lat, S + 2); end
    repeat (5) tick();
    checks++;
    if (value !== 4'h1 || valid !== 1'b1) begin
      failures++; $display("FAIL second_digit: got value=%0h valid=%0b expected 1 1", value, valid);
    end
    checks++;
    if (n_upd - u0 !== 2) begin failures++; $display("FAIL two_updates: got %0d expected 2", n_upd - u0); end
    checks++;
    if (n_serr - s0 !== 0) begin failures++; $display("FAIL first_two_serr: got %0d expected 0", n_serr - s0); end
    check_model("first_two");
  endtask

  task automatic test_sequence();
    int u0, s0;
    apply_reset();
    u0 = n_upd; s0 = n_serr;
    for (int d = 0; d <= 16; d++) drive_digit(d % 16, 22);
    checks++;
    if (n_upd - u0 !== 17) begin failures++; $display("FAIL seq_updates: got %0d expected 17", n_upd - u0); end
    checks++;
    if (n_serr - s0 !== 0) begin failures++; $display("FAIL seq_step_err: got %0d expected 0", n_serr - s0); end
    checks++;
    if (err_count !== 8'h00 || value !== 4'h0) begin
      failures++; $display("FAIL seq_final: got cnt=%0h value=%0h expected 0 0", err_count, value);
    end
    check_model("sequence");
  endtask

  task automatic test_glitch();
    int u0;
    drive_digit(3, 22);
    u0 = n_upd;
    drive(~(tbl[3] ^ 7'h01), 5);
    drive_digit(3, 30);
    checks++;
    if (n_upd - u0 !== 0) begin failures++; $display("FAIL glitch_updates: got %0d expected 0", n_upd - u0); end
    checks++;
    if (value !== 4'h3 || valid !== 1'b1) begin
      failures++; $display("FAIL glitch_value: got value=%0h valid=%0b expected 3 1", value, valid);
    end
    check_model("glitch");
  endtask

  task automatic test_step_err();
    int s0;
    apply_reset();
    drive_digit(2, 22);
    s0 = n_serr;
    drive_digit(5, 22);
    checks++;
    if (n_serr - s0 !== 1) begin failures++; $display("FAIL bad_step_pulse: got %0d expected 1", n_serr - s0); end
    checks++;
    if (err_count !== 8'd1) begin failures++; $display("FAIL bad_step_count: got %0d expected 1", err_count); end
    drive(MASK, 22);
    checks++;
    if (valid !== 1'b0 || invalid_pattern !== 1'b1 || value !== 4'h5) begin
      failures++;
      $display("FAIL blank: got valid=%0b inv=%0b value=%0h expected 0 1 5", valid, invalid_pattern, value);
    end
    s0 = n_serr;
    drive_digit(7, 22);
    checks++;
    if (n_serr - s0 !== 0 || value !== 4'h7 || valid !== 1'b1) begin
      failures++;
      $display("FAIL after_invalid: got serr=%0d value=%0h valid=%0b expected 0 7 1", n_serr - s0, value, valid);
    end
    check_model("step_err");
  endtask

  task automatic test_reset_settling();
    int lat;
    drive_digit(8, 22);
    seg_in = ~tbl[9];
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({value, valid, invalid_pattern, update, step_err, err_count} !== 16'h0000) begin
      failures++;
      $display("FAIL mid_settle_reset: got value=%0h valid=%0b cnt=%0h, expected all 0", value, valid, err_count);
    end
    rst_n = 1'b1;
    measure(~tbl[9], lat);
    checks++;
    if (lat !== S + 2) begin failures++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, S + 2); end
    tick();
    checks++;
    if (value !== 4'h9 || valid !== 1'b1) begin
      failures++; $display("FAIL post_reset_value: got value=%0h valid=%0b expected 9 1", value, valid);
    end
    check_model("reset_settling");
  endtask

  task automatic test_saturate();
    int s0;
    apply_reset();
    s0 = n_serr;
    for (int k = 0; k < 260; k++) begin
      drive_digit((k % 2 == 1) ? 2 : 0, 20);
      if (k == 254) begin
        checks++;
        if (err_count !== 8'd254) begin failures++; $display("FAIL pre_saturate: got %0d expected 254", err_count); end
      end
    end
    checks++;
    if (err_count !== 8'hFF) begin failures++; $display("FAIL saturate: got %0h expected ff", err_count); end
    checks++;
    if (n_serr - s0 !== 259) begin failures++; $display("FAIL saturate_pulses: got %0d expected 259", n_serr - s0); end
    check_model("saturate");
  endtask

  task automatic test_random();
    int kind;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 4);
      if (kind <= 2)      drive_digit($urandom_range(0, 15), $urandom_range(1, 40));
      else if (kind == 3) drive(7'($urandom), $urandom_range(1, 40));
      else                drive(MASK, $urandom_range(1, 40));
    end
    drive(seg_in, 25);
    check_model("random");
    checks++;
    if (value !== 4'(m_val) || valid !== m_v || err_count !== 8'(m_cnt)) begin
      failures++;
      $display("FAIL random_final: got value=%0h valid=%0b cnt=%0h expected %0h %0b %0h",
               value, valid, err_count, m_val, m_v, m_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    seg_in = MASK;
    test_reset();
    test_first_two();
    test_sequence();
    test_glitch();
    test_step_err();
    test_reset_settling();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
